// File: rtl/nbc_pkg.sv
// Shared types and width helpers for the sequential naive Bayes classifier.
package nbc_pkg;

  localparam int DEF_N_FEAT  = 784;
  localparam int DEF_N_CLASS = 10;
  localparam int DEF_PROB_W  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int row_of(input int n_feat);
    return 2 * n_feat + 1;
  endfunction

  // The sum of n_feat+1 words of prob_w bits always fits, so no saturation is needed.
  function automatic int acc_w_of(input int n_feat, input int prob_w);
    return prob_w + $clog2(n_feat + 1);
  endfunction

  function automatic int addr_w_of(input int n_feat, input int n_class);
    return $clog2(n_class * (2 * n_feat + 1));
  endfunction

endpackage

// File: rtl/nbc_argmin.sv
// Streaming arg-min over per-class scores; with NBC_SCORE_OUT_EN it also tracks the runner-up.
module nbc_argmin
  import nbc_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int LBL_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             vld,
  input  logic             first,
  input  logic [ACC_W-1:0] score,
  input  logic [LBL_W-1:0] idx,
  output logic [LBL_W-1:0] best_idx_nx,
  output logic [ACC_W-1:0] best_score_nx
`ifdef NBC_SCORE_OUT_EN
  ,
  output logic [ACC_W-1:0] margin_nx
`endif
);

  logic [ACC_W-1:0] best_q;
  logic [LBL_W-1:0] idx_q;

  // Strictly-less keeps the lower index on ties.
  always_comb begin
    best_score_nx = best_q;
    best_idx_nx   = idx_q;
    if (vld && (first || score < best_q)) begin
      best_score_nx = score;
      best_idx_nx   = idx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      best_q <= '0;
      idx_q  <= '0;
    end else if (clr) begin
      best_q <= '0;
      idx_q  <= '0;
    end else begin
      best_q <= best_score_nx;
      idx_q  <= best_idx_nx;
    end
  end

`ifdef NBC_SCORE_OUT_EN
  logic [ACC_W-1:0] sec_q, sec_nx;

  // All-ones exceeds any reachable total, so it is a safe "no runner-up yet" marker.
  always_comb begin
    sec_nx = sec_q;
    if (vld) begin
      if (first)              sec_nx = '1;
      else if (score < best_q) sec_nx = best_q;
      else if (score < sec_q)  sec_nx = score;
    end
    margin_nx = sec_nx - best_score_nx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    sec_q <= '0;
    else if (clr) sec_q <= '0;
    else          sec_q <= sec_nx;
  end
`endif

endmodule

// File: rtl/nbc_seq_classifier.sv
// Sequential naive Bayes classifier: streams ROM costs per class and reports the arg-min class.
// Optional NBC_SCORE_OUT_EN adds best_score and margin outputs.
module nbc_seq_classifier
  import nbc_pkg::*;
#(
  parameter  int N_FEAT  = DEF_N_FEAT,
  parameter  int N_CLASS = DEF_N_CLASS,
  parameter  int PROB_W  = DEF_PROB_W,
  localparam int ROW     = row_of(N_FEAT),
  localparam int ADDR_W  = addr_w_of(N_FEAT, N_CLASS),
  localparam int ACC_W   = acc_w_of(N_FEAT, PROB_W),
  localparam int LBL_W   = $clog2(N_CLASS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [N_FEAT-1:0] test_vector,
  output logic              busy,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PROB_W-1:0] rom_dout,
  output logic              label_valid,
  output logic [LBL_W-1:0]  label
`ifdef NBC_SCORE_OUT_EN
  ,
  output logic [ACC_W-1:0]  best_score,
  output logic [ACC_W-1:0]  margin
`endif
);

  localparam int FEAT_W = $clog2(N_FEAT + 1);

  state_t              state;
  logic [N_FEAT-1:0]   vec_q;
  logic [FEAT_W-1:0]   feat, feat_nx;
  logic [LBL_W-1:0]    cls;
  logic [ADDR_W-1:0]   base, nx_addr;
  logic                last_feat, last_cls;
  logic                tag_vld, tag_first, tag_last;
  logic [LBL_W-1:0]    tag_cls;
  logic [ACC_W-1:0]    acc, sum;
  logic [LBL_W-1:0]    best_idx_nx;
  logic [ACC_W-1:0]    best_score_nx;
`ifdef NBC_SCORE_OUT_EN
  logic [ACC_W-1:0]    margin_nx;
`endif

  // feat == N_FEAT denotes the prior read that closes a class.
  always_comb begin
    last_feat = (feat == FEAT_W'(N_FEAT));
    last_cls  = (cls == LBL_W'(N_CLASS - 1));
    feat_nx   = feat + FEAT_W'(1);
    if (last_feat)
      nx_addr = base + ADDR_W'(ROW) + ADDR_W'(vec_q[0]);
    else if (feat_nx == FEAT_W'(N_FEAT))
      nx_addr = base + ADDR_W'(2 * N_FEAT);
    else
      nx_addr = base + (ADDR_W'(feat_nx) << 1) + ADDR_W'(vec_q[feat_nx]);
  end

  assign sum = (tag_first ? '0 : acc) + ACC_W'(rom_dout);

  nbc_argmin #(.ACC_W(ACC_W), .LBL_W(LBL_W)) u_argmin (
    .clk          (clk),
    .rstn         (rstn),
    .clr          (state == IDLE && start),
    .vld          (tag_vld && tag_last),
    .first        (tag_cls == '0),
    .score        (sum),
    .idx          (tag_cls),
    .best_idx_nx  (best_idx_nx),
    .best_score_nx(best_score_nx)
`ifdef NBC_SCORE_OUT_EN
    ,
    .margin_nx    (margin_nx)
`endif
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      vec_q       <= '0;
      feat        <= '0;
      cls         <= '0;
      base        <= '0;
      acc         <= '0;
      tag_vld     <= 1'b0;
      tag_first   <= 1'b0;
      tag_last    <= 1'b0;
      tag_cls     <= '0;
      busy        <= 1'b0;
      rom_en      <= 1'b0;
      rom_addr    <= '0;
      label_valid <= 1'b0;
      label       <= '0;
`ifdef NBC_SCORE_OUT_EN
      best_score  <= '0;
      margin      <= '0;
`endif
    end else begin
      // Tags describe the read issued this cycle; they line up with rom_dout next cycle.
      tag_vld   <= rom_en;
      tag_first <= (feat == '0);
      tag_last  <= last_feat;
      tag_cls   <= cls;
      if (tag_vld) acc <= sum;
      case (state)
        IDLE: begin
          label_valid <= 1'b0;
          if (start) begin
            vec_q    <= test_vector;
            feat     <= '0;
            cls      <= '0;
            base     <= '0;
            acc      <= '0;
            rom_en   <= 1'b1;
            rom_addr <= ADDR_W'(test_vector[0]);
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (last_feat && last_cls) begin
            rom_en <= 1'b0;
            state  <= DRAIN;
          end else begin
            rom_addr <= nx_addr;
            if (last_feat) begin
              feat <= '0;
              cls  <= cls + LBL_W'(1);
              base <= base + ADDR_W'(ROW);
            end else begin
              feat <= feat_nx;
            end
          end
        end
        DRAIN: begin
          // Final class is compared this cycle, so take the arg-min's next value.
          label       <= best_idx_nx;
          label_valid <= 1'b1;
          busy        <= 1'b0;
`ifdef NBC_SCORE_OUT_EN
          best_score  <= best_score_nx;
          margin      <= margin_nx;
`endif
          state       <= DONE;
        end
        DONE: begin
          label_valid <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nbc_seq_classifier.md
Name: nbc_seq_classifier

Overview:
- Parametrised successor to the fixed 784-feature, 10-class naive Bayes classifier.
- Accepts one binary feature vector per start/done transaction and latches it.
- Streams per-class cost words from an external synchronous ROM, accumulates a cost per class including a per-class prior, and reports the arg-min class.
- Sits between the test-vector source (CPU register bank) and the ROM of quantised -log2 probabilities.

Parameters:
- N_FEAT, 784, number of binary features.
- N_CLASS, 10, number of classes (≥2).
- PROB_W, 10, ROM cost word width (unsigned, -log2 p scaled).
- ROW, 2*N_FEAT+1, ROM words per class (derived localparam).
- ADDR_W, $clog2(N_CLASS*ROW), ROM address width (14 at defaults).
- ACC_W, PROB_W+$clog2(N_FEAT+1), accumulator width (20 at defaults).
- LBL_W, $clog2(N_CLASS), label width (4 at defaults).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  start request, sampled only in IDLE.
- test_vector  in  N_FEAT  features; bit f is feature f; latched on an accepted start.
- busy  out  1  high from the cycle after acceptance until label_valid.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_W  ROM address.
- rom_dout  in  PROB_W  ROM data, valid one cycle after rom_en.
- label_valid  out  1  one-cycle pulse, result valid.
- label  out  LBL_W  winning class, held until the next accepted start.

Behaviour:
- ROM layout: word c*ROW + 2f + b holds the cost of feature f == b for class c; word c*ROW + 2N_FEAT holds the class prior cost.
- Address generation uses an incrementing base register (base += ROW per class); no multiplier.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 latches test_vector into vec_q and zeroes counters, acc, best_score, best_idx. Go to RUN.
- RUN: one read per cycle, rom_en=1. Per class: features f=0..N_FEAT-1 at address base+2f+vec_q[f], then the prior at base+2N_FEAT. This is N_FEAT+1 reads per class.
- The last read of the last class moves the FSM to DRAIN.
- Accumulate: a 1-cycle-delayed valid/first/last tag travels with each read. On tagged data, acc <= (first ? 0 : acc) + rom_dout, zero-extended to ACC_W. No saturation is needed: the width is sufficient by construction.
- Class end: on the cycle the last tag is seen, compare acc+rom_dout against best_score.
  - Class 0 always loads.
  - Otherwise strictly-less wins, so ties go to the lower class index.
  - Update best_score and best_idx.
- DRAIN: one cycle while the final data word is consumed and compared. Go to DONE.
- DONE: label <= best_idx, label_valid=1 for exactly one cycle. Go to IDLE.
- Latency: start accepted at cycle 0 gives rom_en on cycles 1..N_CLASS*(N_FEAT+1) and label_valid on cycle N_CLASS*(N_FEAT+1)+2. That is cycle 7852 at defaults.
- start while busy is ignored. start in the same cycle as label_valid is ignored. start in the following IDLE cycle is accepted.
- test_vector changes after acceptance have no effect.
- rom_addr holds its last value when rom_en=0.
- Reset mid-run aborts immediately. Reset values: label_valid=0, busy=0, rom_en=0, rom_addr=0, label=0, FSM=IDLE, all counters and accumulators 0.

Optional Feature:
- Macro: NBC_SCORE_OUT_EN.
- When defined, adds output ports best_score[ACC_W] (winning total cost) and margin[ACC_W] (runner-up cost minus winning cost, unsigned). Both are updated with label.
- The runner-up tracks the second-smallest cost, with ties resolved as for the winner; equal costs give margin 0.
- When undefined, neither the ports nor the runner-up registers exist, and the rest of the behaviour is identical.

Decomposition:
- Package nbc_pkg holds:
  - FSM state enum.
  - Default N_FEAT/N_CLASS/PROB_W constants.
  - Functions for the ROW/ACC_W/ADDR_W width calculations.
- One sub-module, nbc_argmin: streaming compare/update of best (and runner-up under the macro), given score, index, valid and first.
- The core keeps the FSM, address generation and accumulator.

Test Plan:
- N_FEAT=4, N_CLASS=3, costs chosen so class totals are 20, 12, 15; vector 4'b1010 → label=1 at cycle 17, label_valid high for 1 cycle, busy low afterwards. With the macro: best_score=12, margin=3.
- Class totals 9, 9, 11 → label=0, the tie resolved to the lower index. With the macro: margin=0.
- All ROM words 2^PROB_W-1 at default parameters → no overflow; best_score=785*1023=803055; label=0; label_valid at cycle 7852.
- start pulsed during RUN and test_vector toggled mid-run → ignored; result matches the vector latched at start.
- rstn asserted at cycle 100 of a run → rom_en, busy, label_valid drop at once and label=0. A new start after release completes normally with the correct label.
- ROM address check: scoreboard compares each rom_addr against c*ROW+2f+vec[f] and then c*ROW+2N_FEAT, in order, with no gaps.
